muldiv_unit: RTL and testbench

- Iterative signed multiply/divide unit downstream of the function/opcode decoder.
- Consumes the decoder's one-hot mult/div strobes and the register-file operands, then produces the HI/LO results that the decoder's selector codes 3'b010/3'b011 route to write-back.
- Asserts busy for the duration of an operation so the pipeline stalls.
- Uses a radix-2 shift/add multiply and a restoring divide, with pre/post sign correction.

---
 rtl/muldiv_pkg.sv | 23 ++
 rtl/muldiv_step.sv | 37 +++
 rtl/muldiv_unit.sv | 119 +++++++++++
 tb/tb_muldiv_unit.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and sizing helpers for the iterative signed multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_t;

  // One extra bit so the counter can represent WIDTH itself.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned CNT_W     = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: radix-2 shift/add multiply or restoring divide.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int unsigned WP = WIDTH + 1;

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic           ge;

  always_comb begin
    hi_out  = hi_in;
    lo_out  = lo_in;
    sum     = {1'b0, hi_in} + ({1'b0, opnd} & {WP{lo_in[0]}});
    shifted = {hi_in, lo_in[WIDTH-1]};
    ge      = (shifted >= {1'b0, opnd});
    if (op == OP_MULT) begin
      hi_out = sum[WIDTH:1];
      lo_out = {sum[0], lo_in[WIDTH-1:1]};
    end else begin
      // The restored remainder is always below the divisor, so WIDTH bits suffice.
      hi_out = ge ? (shifted[WIDTH-1:0] - opnd) : shifted[WIDTH-1:0];
      lo_out = {lo_in[WIDTH-2:0], ge};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed multiply/divide producing HI/LO; busy stalls the pipeline while it runs.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mult,
  input  logic             div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam int unsigned W2 = 2 * WIDTH;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  op_t              op_q;
  logic             neg_q, neg_a_q, div0_q;
  logic [WIDTH-1:0] opnd_q, acc_hi_q, acc_lo_q;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  logic [W2-1:0]    prod, prod_fix;
  logic             start, last;

  assign start = mult | div;
  assign last  = (cnt_q == CW'(WIDTH - 1));

  // Most-negative maps onto itself, which reads correctly as unsigned 2^(WIDTH-1).
  assign a_abs = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
  assign b_abs = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;

  assign prod     = {acc_hi_q, acc_lo_q};
  assign prod_fix = neg_q   ? (~prod + W2'(1))        : prod;
  assign quo_fix  = neg_q   ? (~acc_lo_q + WIDTH'(1)) : acc_lo_q;
  assign rem_fix  = neg_a_q ? (~acc_hi_q + WIDTH'(1)) : acc_hi_q;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .op     (op_q),
    .hi_in  (acc_hi_q),
    .lo_in  (acc_lo_q),
    .opnd   (opnd_q),
    .hi_out (step_hi),
    .lo_out (step_lo)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_CALC;
      S_CALC:  if (last)  state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      cnt_q    <= '0;
      op_q     <= OP_MULT;
      neg_q    <= 1'b0;
      neg_a_q  <= 1'b0;
      div0_q   <= 1'b0;
      opnd_q   <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
    end else begin
      busy <= (state_d != S_IDLE);
      done <= (state_q == S_FIX);
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q     <= mult ? OP_MULT : OP_DIV;
            cnt_q    <= '0;
            neg_q    <= a[WIDTH-1] ^ b[WIDTH-1];
            neg_a_q  <= a[WIDTH-1];
            div0_q   <= (b == '0);
            acc_hi_q <= '0;
            acc_lo_q <= mult ? b_abs : a_abs;
            opnd_q   <= mult ? a_abs : b_abs;
          end
        end
        S_CALC: begin
          acc_hi_q <= step_hi;
          acc_lo_q <= step_lo;
          cnt_q    <= cnt_q + CW'(1);
        end
        S_FIX: begin
          if (op_q == OP_MULT) begin
            hi <= prod_fix[W2-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end else begin
            // Divide by zero leaves |a| in the remainder, so hi reproduces a.
            hi <= rem_fix;
            lo <= div0_q ? '1 : quo_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed checks of muldiv_unit: latency, signed results, corner cases, reset and start handling.
module tb_muldiv_unit;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         mult;
  logic         div;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks = 0;
  int errors = 0;
  int lat, bc, nd;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .mult (mult),
    .div  (div),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive a start for one edge, then scramble the operands.
  task automatic start_op(input logic m, input logic d, input logic [W-1:0] aa, input logic [W-1:0] bb);
    mult = m;
    div  = d;
    a    = aa;
    b    = bb;
    @(posedge clk);
    #1;
    mult = 1'b0;
    div  = 1'b0;
    a    = $urandom;
    b    = $urandom;
  endtask

  // Edges from now until done is seen (bounded), counting busy-high samples.
  task automatic wait_done(output int l, output int bcount);
    l      = 0;
    bcount = 0;
    while (done !== 1'b1 && l < 100) begin
      if (busy === 1'b1) bcount++;
      @(posedge clk);
      #1;
      l++;
    end
  endtask

  task automatic run(input string tag, input logic m, input logic d,
                     input logic [W-1:0] aa, input logic [W-1:0] bb,
                     input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
    int l, bcount;
    start_op(m, d, aa, bb);
    wait_done(l, bcount);
    chk({tag, "_lat"}, 64'(l), 64'd33);
    chk({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    chk({tag, "_lo"}, 64'(lo), 64'(exp_lo));
  endtask

  initial begin
    rst  = 1'b1;
    mult = 1'b0;
    div  = 1'b0;
    a    = '0;
    b    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 7 * -3, with latency and busy length
    start_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
    wait_done(lat, bc);
    chk("m7x-3_lat", 64'(lat), 64'd33);
    chk("m7x-3_busy", 64'(bc), 64'd33);
    chk("m7x-3_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("m7x-3_lo", 64'(lo), 64'hFFFF_FFEB);
    @(posedge clk);
    #1;
    chk("m7x-3_done_pulse", 64'(done), 64'd0);
    chk("m7x-3_idle", 64'(busy), 64'd0);

    run("d100/7", 1'b0, 1'b1, 32'd100, 32'd7, 32'd2, 32'd14);
    run("d-7/2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("d5/0", 1'b0, 1'b1, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    run("dovf", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

    // Most-negative squared, with a divide request injected mid-operation
    start_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000);
    repeat (5) @(posedge clk);
    #1;
    div = 1'b1;
    a   = 32'd9;
    b   = 32'd3;
    @(posedge clk);
    #1;
    div = 1'b0;
    wait_done(lat, bc);
    chk("mneg_lat", 64'(lat), 64'd27);
    chk("mneg_hi", 64'(hi), 64'h4000_0000);
    chk("mneg_lo", 64'(lo), 64'd0);
    nd = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) nd++;
    end
    chk("mneg_extra_done", 64'(nd), 64'd0);
    chk("mneg_hold_hi", 64'(hi), 64'h4000_0000);
    chk("mneg_hold_lo", 64'(lo), 64'd0);

    // Reset in the middle of a multiply
    start_op(1'b1, 1'b0, 32'h0000_1234, 32'h0000_5678);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_hi", 64'(hi), 64'd0);
    chk("midrst_lo", 64'(lo), 64'd0);
    nd = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) nd++;
    end
    chk("midrst_quiet", 64'(nd), 64'd0);
    run("m6x7", 1'b1, 1'b0, 32'd6, 32'd7, 32'd0, 32'd42);

    // Both strobes: multiply wins; then a start in the done cycle
    run("both9x4", 1'b1, 1'b1, 32'd9, 32'd4, 32'd0, 32'd36);
    chk("b2b_done_cycle", 64'(done), 64'd1);
    start_op(1'b1, 1'b0, 32'd3, 32'hFFFF_FFFB);
    chk("b2b_busy", 64'(busy), 64'd1);
    wait_done(lat, bc);
    chk("b2b_lat", 64'(lat), 64'd33);
    chk("b2b_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("b2b_lo", 64'(lo), 64'hFFFF_FFF1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
